bus_responder: RTL



---
 rtl/bus_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bus_responder.sv
// Bus responder: target end of the core's multiplexed ALE/nME/nOE/nWE bus, backed by a word array.
// Latency: read data valid WAIT_STATES+1 cycles after the strobe edge; nWait is low for WAIT_STATES cycles.
// Backpressure: nWait stalls the core; optional mailbox IRQ on the top word when BUS_RESPONDER_IRQ_EN is defined.
module bus_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [15:0] BASE        = 16'h0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_bus_in,
  input  logic        i_ale,
  input  logic        i_nme,
  input  logic        i_noe,
  input  logic        i_nwe,
  output logic [15:0] o_data_in,
  output logic        o_data_en,
  output logic        o_nwait,
  output logic        o_nirq
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCESS = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);
`ifdef BUS_RESPONDER_IRQ_EN
  localparam logic [ADDR_W-1:0] LP_MBOX = '1;
`endif

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [3:0]          r_count, w_count_nxt;
  logic                r_is_read, w_is_read_nxt;
  logic [15:0]         r_data_in, w_data_in_nxt;
  logic                r_data_en, w_data_en_nxt;
  logic                r_nwait, w_nwait_nxt;
  logic                r_nirq, w_nirq_nxt;
  logic                w_hit;
  logic                w_mem_we;
  logic [15:0]         r_mem [2**ADDR_W];

  // Window decode: upper address bits must equal BASE
  assign w_hit = (i_bus_in[15:ADDR_W] == BASE[15-ADDR_W:0]);

  // Next-state and registered-output computation for the bus cycle FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_count_nxt   = r_count;
    w_is_read_nxt = r_is_read;
    w_data_in_nxt = r_data_in;
    w_data_en_nxt = r_data_en;
    w_nwait_nxt   = r_nwait;
    w_nirq_nxt    = r_nirq;
    w_mem_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A miss is simply ignored; nothing else moves
        if (i_ale && w_hit) begin
          w_addr_nxt  = i_bus_in[ADDR_W-1:0];
          w_state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (i_ale) begin
          if (w_hit) begin
            w_addr_nxt = i_bus_in[ADDR_W-1:0];
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (!i_nme && (i_noe != i_nwe)) begin
          // Exactly one strobe low; both low is a protocol error and waits here
          w_is_read_nxt = !i_noe;
          w_count_nxt   = LP_WAIT;
          if (LP_WAIT != 4'd0) begin
            w_nwait_nxt = 1'b0;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (i_nme) begin
          // Core abandoned the cycle: release nWait, never touch the array
          w_nwait_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - 4'd1;
          if (r_count == 4'd1) begin
            w_nwait_nxt = 1'b1;
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (r_is_read) begin
          w_data_in_nxt = r_mem[r_addr];
          w_data_en_nxt = 1'b1;
        end else begin
          w_mem_we = 1'b1;
        end
`ifdef BUS_RESPONDER_IRQ_EN
        // Mailbox: a write raises the interrupt, a read acknowledges it
        if (r_addr == LP_MBOX) begin
          w_nirq_nxt = r_is_read;
        end
`endif
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // DataIn keeps its last value after the drive enable drops
        if (i_nme || (r_is_read && i_noe)) begin
          w_data_en_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_count   <= 4'd0;
      r_is_read <= 1'b0;
      r_data_in <= 16'h0000;
      r_data_en <= 1'b0;
      r_nwait   <= 1'b1;
      r_nirq    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_count   <= w_count_nxt;
      r_is_read <= w_is_read_nxt;
      r_data_in <= w_data_in_nxt;
      r_data_en <= w_data_en_nxt;
      r_nwait   <= w_nwait_nxt;
      r_nirq    <= w_nirq_nxt;
    end
  end

  // Array write at the ACCESS edge; contents survive reset, and a write caught by reset is dropped
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_mem_we) begin
      r_mem[r_addr] <= i_bus_in;
    end
  end

  assign o_data_in = r_data_in;
  assign o_data_en = r_data_en;
  assign o_nwait   = r_nwait;
  assign o_nirq    = r_nirq;

endmodule
